// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle fill engine: FSM state encoding and draw modes.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_FILL    = 2'b00,
        MODE_OUTLINE = 2'b01,
        MODE_CLEAR   = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    function automatic logic isOutline(input mode_t m);
        return m == MODE_OUTLINE;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Raster position counter for the fill engine. It presents the position that will be shown
// next cycle, together with last-pixel and rectangle-border flags for that position.
import draw_pkg::*;

module scan_counter #(
    parameter int COORD_W = 9
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [COORD_W-1:0] w_i,
    input  logic [COORD_W-1:0] h_i,
    output logic [COORD_W-1:0] dx_o,
    output logic [COORD_W-1:0] dy_o,
    output logic               last_o,
    output logic               border_o
);

    logic [COORD_W-1:0] dx_q, dy_q, dx_d, dy_d;
    logic [COORD_W-1:0] wLast, hLast;

    assign wLast = w_i - COORD_W'(1);
    assign hLast = h_i - COORD_W'(1);

    // Column offset runs fastest; wrapping a row bumps the row offset.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (load_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (step_i) begin
            if (dx_q == wLast) begin
                dx_d = '0;
                dy_d = dy_q + COORD_W'(1);
            end else begin
                dx_d = dx_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx_o     = dx_d;
    assign dy_o     = dy_d;
    assign last_o   = (dx_d == wLast) && (dy_d == hLast);
    assign border_o = (dx_d == '0) || (dx_d == wLast) || (dy_d == '0) || (dy_d == hLast);

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill / outline / clear-screen engine feeding a VGA adapter one pixel per cycle,
// with off-screen positions suppressed by gating plot rather than shortening the scan.
import draw_pkg::*;

module rect_fill_engine #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int COORD_W  = 9,
    parameter int COLOUR_W = 3
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COORD_W-1:0]  x0,
    input  logic [COORD_W-1:0]  y0,
    input  logic [COORD_W-1:0]  w,
    input  logic [COORD_W-1:0]  h,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam logic [COORD_W-1:0] FULL_W  = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] FULL_H  = COORD_W'(SCREEN_H);
    localparam logic [COORD_W:0]   LIMIT_X = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0]   LIMIT_Y = (COORD_W+1)'(SCREEN_H);

    state_t                state_q;
    mode_t                 mode_q;
    logic [COORD_W-1:0]    x0_q, y0_q, w_q, h_q;
    logic [COLOUR_W-1:0]   colour_q;
    logic [COORD_W-1:0]    x_q, y_q;
    logic                  plot_q, busy_q, done_q, lastShown_q;

    mode_t                 modeSel;
    logic [COORD_W-1:0]    x0Sel, y0Sel, wSel, hSel;
    logic [COORD_W-1:0]    nextDx, nextDy;
    logic                  nextLast, nextBorder;
    logic [COORD_W:0]      sumX, sumY;
    logic                  accept, zeroSize, pixelOn;

    // While idle the incoming command is used directly so the first position can be
    // registered on the accept edge; afterwards the latched copy drives the scan.
    always_comb begin
        modeSel = mode_q;
        x0Sel   = x0_q;
        y0Sel   = y0_q;
        wSel    = w_q;
        hSel    = h_q;
        if (state_q == IDLE) begin
            if (mode_t'(mode) == MODE_CLEAR) begin
                modeSel = MODE_CLEAR;
                x0Sel   = '0;
                y0Sel   = '0;
                wSel    = FULL_W;
                hSel    = FULL_H;
            end else begin
                modeSel = mode_t'(mode);
                x0Sel   = x0;
                y0Sel   = y0;
                wSel    = w;
                hSel    = h;
            end
        end
    end

    assign accept   = (state_q == IDLE) && start;
    assign zeroSize = (wSel == '0) || (hSel == '0);

    scan_counter #(.COORD_W(COORD_W)) u_scan (
        .clk_i    (CLOCK_50),
        .rst_ni   (resetn),
        .load_i   (accept),
        .step_i   ((state_q == SCAN) && !lastShown_q),
        .w_i      (wSel),
        .h_i      (hSel),
        .dx_o     (nextDx),
        .dy_o     (nextDy),
        .last_o   (nextLast),
        .border_o (nextBorder)
    );

    assign sumX    = {1'b0, x0Sel} + {1'b0, nextDx};
    assign sumY    = {1'b0, y0Sel} + {1'b0, nextDy};
    assign pixelOn = (sumX < LIMIT_X) && (sumY < LIMIT_Y) &&
                     (!isOutline(modeSel) || nextBorder);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mode_q      <= MODE_FILL;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            colour_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lastShown_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    plot_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (accept) begin
                        mode_q   <= modeSel;
                        x0_q     <= x0Sel;
                        y0_q     <= y0Sel;
                        w_q      <= wSel;
                        h_q      <= hSel;
                        colour_q <= colour_in;
                        busy_q   <= 1'b1;
                        if (zeroSize) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= SCAN;
                            x_q         <= sumX[COORD_W-1:0];
                            y_q         <= sumY[COORD_W-1:0];
                            plot_q      <= pixelOn;
                            lastShown_q <= nextLast;
                        end
                    end
                end
                SCAN: begin
                    if (lastShown_q) begin
                        state_q     <= DONE;
                        plot_q      <= 1'b0;
                        done_q      <= 1'b1;
                        lastShown_q <= 1'b0;
                    end else begin
                        x_q         <= sumX[COORD_W-1:0];
                        y_q         <= sumY[COORD_W-1:0];
                        plot_q      <= pixelOn;
                        lastShown_q <= nextLast;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: directed commands push expected pixels, a negedge
// monitor pops and compares every plotted pixel, and the stimulus side checks timing.
module tb_rect_fill_engine;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] mode;
    logic [8:0] x0, y0, w, h;
    logic [2:0] colour_in;
    logic [8:0] x, y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t expQ[$];
    pix_t monExp;

    always #10 CLOCK_50 = ~CLOCK_50;

    rect_fill_engine dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .mode      (mode),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .colour_in (colour_in),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushPix(input int px, input int py, input int pc);
        expQ.push_back('{px, py, pc});
    endtask

    // Every plotted pixel must be the next one the scoreboard expects.
    always @(negedge CLOCK_50) begin
        if (resetn && plot) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_plot: got (%0d,%0d) colour %0d, expected no plot",
                         x, y, colour);
            end else begin
                monExp = expQ.pop_front();
                if (int'(x) != monExp.px || int'(y) != monExp.py || int'(colour) != monExp.pc) begin
                    miscompares++;
                    $display("[TB] FAIL pixel: got (%0d,%0d) colour %0d, expected (%0d,%0d) colour %0d",
                             x, y, colour, monExp.px, monExp.py, monExp.pc);
                end
            end
        end
    end

    // Issues one command (caller is at negedge+1 of an IDLE cycle) and checks its timing.
    task automatic applyStimulus(input logic [1:0] m, input int px0, input int py0,
                                 input int pw, input int ph, input logic [2:0] col,
                                 input int expDoneAt, input int expPlots, input bit midStart);
        int cyc     = 0;
        int plots   = 0;
        int busyLow = 0;
        int doneAt  = 0;
        int firstAt = 0;
        mode      = m;
        x0        = px0[8:0];
        y0        = py0[8:0];
        w         = pw[8:0];
        h         = ph[8:0];
        colour_in = col;
        start     = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        while (doneAt == 0 && cyc < expDoneAt + 10) begin
            @(negedge CLOCK_50);
            #1 cyc++;
            if (plot) begin
                plots++;
                if (firstAt == 0) firstAt = cyc;
            end
            if (!busy) busyLow++;
            if (done) doneAt = cyc;
            if (midStart && cyc == 100) begin
                mode  = 2'b00;
                x0    = 9'd5;
                w     = 9'd1;
                h     = 9'd1;
                start = 1'b1;
            end
            if (midStart && cyc == 101) start = 1'b0;
        end
        checkOutput("done_cycle", doneAt, expDoneAt);
        checkOutput("plot_count", plots, expPlots);
        checkOutput("busy_low_cycles", busyLow, 0);
        if (expPlots > 0) checkOutput("first_plot_cycle", firstAt, 1);
        @(negedge CLOCK_50);
        #1;
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_done", int'(done), 0);
        checkOutput("queue_left", expQ.size(), 0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        mode      = 2'b00;
        x0        = '0;
        y0        = '0;
        w         = '0;
        h         = '0;
        colour_in = '0;
        repeat (2) @(negedge CLOCK_50);
        #1;
        checkOutput("rst_x", int'(x), 0);
        checkOutput("rst_y", int'(y), 0);
        checkOutput("rst_colour", int'(colour), 0);
        checkOutput("rst_plot", int'(plot), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        resetn = 1'b1;

        // Basic fill
        pushPix(10, 20, 4); pushPix(11, 20, 4); pushPix(12, 20, 4);
        pushPix(10, 21, 4); pushPix(11, 21, 4); pushPix(12, 21, 4);
        applyStimulus(2'b00, 10, 20, 3, 2, 3'b100, 7, 6, 1'b0);

        // Clipping at the bottom-right corner
        pushPix(318, 239, 5); pushPix(319, 239, 5);
        applyStimulus(2'b00, 318, 239, 4, 2, 3'b101, 9, 2, 1'b0);

        // Outline skips interior (1,1) and (2,1)
        pushPix(0, 0, 2); pushPix(1, 0, 2); pushPix(2, 0, 2); pushPix(3, 0, 2);
        pushPix(0, 1, 2); pushPix(3, 1, 2);
        pushPix(0, 2, 2); pushPix(1, 2, 2); pushPix(2, 2, 2); pushPix(3, 2, 2);
        applyStimulus(2'b01, 0, 0, 4, 3, 3'b010, 13, 10, 1'b0);

        // Reserved mode behaves as fill
        pushPix(5, 6, 3); pushPix(6, 6, 3);
        applyStimulus(2'b11, 5, 6, 2, 1, 3'b011, 3, 2, 1'b0);

        // Single pixel
        pushPix(100, 200, 6);
        applyStimulus(2'b00, 100, 200, 1, 1, 3'b110, 2, 1, 1'b0);

        // Degenerate sizes
        applyStimulus(2'b00, 10, 10, 0, 5, 3'b001, 1, 0, 1'b0);
        applyStimulus(2'b01, 10, 10, 5, 0, 3'b001, 1, 0, 1'b0);

        // Clear screen ignores x0/y0/w/h and a mid-scan start
        for (int yy = 0; yy < 240; yy++)
            for (int xx = 0; xx < 320; xx++)
                pushPix(xx, yy, 0);
        applyStimulus(2'b10, 7, 9, 3, 3, 3'b000, 76801, 76800, 1'b1);

        // Reset in the middle of a 10x10 fill: 30 pixels shown, then abandoned
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 10; xx++)
                pushPix(50 + xx, 50 + yy, 7);
        mode      = 2'b00;
        x0        = 9'd50;
        y0        = 9'd50;
        w         = 9'd10;
        h         = 9'd10;
        colour_in = 3'b111;
        start     = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        #2 resetn = 1'b0;
        #1;
        checkOutput("midrst_x", int'(x), 0);
        checkOutput("midrst_y", int'(y), 0);
        checkOutput("midrst_colour", int'(colour), 0);
        checkOutput("midrst_plot", int'(plot), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_queue", expQ.size(), 0);
        repeat (3) begin
            @(negedge CLOCK_50);
            #1 checkOutput("midrst_no_done", int'(done), 0);
        end
        resetn = 1'b1;

        // Full run after reset release
        for (int yy = 0; yy < 10; yy++)
            for (int xx = 0; xx < 10; xx++)
                pushPix(50 + xx, 50 + yy, 5);
        applyStimulus(2'b00, 50, 50, 10, 10, 3'b101, 101, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
